// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register
// and the latched external interrupt request.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Wen,
  input  logic        IF_Wen,
  input  logic        IF_Flush,
  input  logic        branch_hazard,
  input  logic [31:0] branch_target,
  input  logic        jump_hazard,
  input  logic [31:0] jump_target,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        IF_ID_valid,
  output logic        IF_ID_irq
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcPlus4;
  logic        r_valid;
  logic        r_irq;
  logic        r_irqPending;

  logic [31:0] w_pcPlus4;
  logic [31:0] w_nextPc;
  logic        w_irqTake;

  assign w_pcPlus4 = r_pc + 32'd4;

  // Interrupts only enter from user space on a plain sequential-advance cycle.
  assign w_irqTake = r_irqPending && !r_pc[31] && PC_Wen && !branch_hazard && !jump_hazard;

  always_comb begin
    w_nextPc = w_pcPlus4;
    if (branch_hazard)    w_nextPc = branch_target;
    else if (!PC_Wen)     w_nextPc = r_pc;
    else if (jump_hazard) w_nextPc = jump_target;
    else if (w_irqTake)   w_nextPc = IRQ_VECTOR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_irqPending <= 1'b0;
    end else begin
      r_pc <= w_nextPc;
      // A take in the same cycle as a new request wins: the request is consumed.
      if (w_irqTake)  r_irqPending <= 1'b0;
      else if (irq)   r_irqPending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= 32'd0;
      r_valid   <= 1'b0;
      r_irq     <= 1'b0;
    end else if (branch_hazard || (IF_Flush && IF_Wen)) begin
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= w_pcPlus4;
      r_valid   <= 1'b0;
      r_irq     <= 1'b0;
    end else if (w_irqTake) begin
      // The bubble carries PC+4 so decode can recover the return address.
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= w_pcPlus4;
      r_valid   <= 1'b0;
      r_irq     <= 1'b1;
    end else if (IF_Wen) begin
      r_instr   <= imem_rdata;
      r_pcPlus4 <= w_pcPlus4;
      r_valid   <= 1'b1;
      r_irq     <= 1'b0;
    end
  end

  assign imem_addr         = r_pc;
  assign PC                = r_pc;
  assign IF_ID_Instruction = r_instr;
  assign IF_ID_PC_plus4    = r_pcPlus4;
  assign IF_ID_valid       = r_valid;
  assign IF_ID_irq         = r_irq;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the fetch stage.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC   = 32'h8000_0000;
   localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        PC_Wen, IF_Wen, IF_Flush;
   logic        branch_hazard, jump_hazard, irq;
   logic [31:0] branch_target, jump_target;
   logic [31:0] imem_addr, imem_rdata, PC;
   logic [31:0] IF_ID_Instruction, IF_ID_PC_plus4;
   logic        IF_ID_valid, IF_ID_irq;

   int checks   = 0;
   int failures = 0;

   // Behavioural view of the stage: architectural PC, decode latch and pending flag.
   logic [31:0] mPc, mInstr, mPcp4;
   logic        mValid, mIrq, mPending;

   if_fetch_stage dut (
      .clk(clk), .reset(reset), .PC_Wen(PC_Wen), .IF_Wen(IF_Wen), .IF_Flush(IF_Flush),
      .branch_hazard(branch_hazard), .branch_target(branch_target),
      .jump_hazard(jump_hazard), .jump_target(jump_target), .irq(irq),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .PC(PC),
      .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_plus4(IF_ID_PC_plus4),
      .IF_ID_valid(IF_ID_valid), .IF_ID_irq(IF_ID_irq)
   );

   always #5 clk = ~clk;

   // Instruction memory returns a word derived from its address so every fetch is traceable.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   assign imem_rdata = memWord(imem_addr);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".PC"},     PC,                 mPc);
      checkOutput({tag, ".addr"},   imem_addr,          mPc);
      checkOutput({tag, ".instr"},  IF_ID_Instruction,  mInstr);
      checkOutput({tag, ".pcp4"},   IF_ID_PC_plus4,     mPcp4);
      checkOutput({tag, ".valid"},  {31'd0, IF_ID_valid}, {31'd0, mValid});
      checkOutput({tag, ".irq"},    {31'd0, IF_ID_irq},   {31'd0, mIrq});
   endtask

   task automatic modelReset();
      mPc = RESET_PC; mInstr = NOP_INSTR; mPcp4 = 32'd0;
      mValid = 1'b0; mIrq = 1'b0; mPending = 1'b0;
   endtask

   // One clock edge of the reference model, evaluated from the rules for the current inputs.
   task automatic modelStep();
      logic        userSpace, redirect, take;
      logic [31:0] seq, pcNew;
      userSpace = (mPc < 32'h8000_0000);
      redirect  = branch_hazard || jump_hazard;
      take      = mPending && userSpace && PC_Wen && !redirect;
      seq       = mPc + 32'd4;

      if (branch_hazard)      pcNew = branch_target;
      else if (!PC_Wen)       pcNew = mPc;
      else if (jump_hazard)   pcNew = jump_target;
      else if (take)          pcNew = IRQ_VECTOR;
      else                    pcNew = seq;

      if (branch_hazard || (IF_Flush && IF_Wen)) begin
         mInstr = NOP_INSTR; mPcp4 = seq; mValid = 1'b0; mIrq = 1'b0;
      end else if (take) begin
         mInstr = NOP_INSTR; mPcp4 = seq; mValid = 1'b0; mIrq = 1'b1;
      end else if (IF_Wen) begin
         mInstr = memWord(mPc); mPcp4 = seq; mValid = 1'b1; mIrq = 1'b0;
      end

      mPending = take ? 1'b0 : (mPending | irq);
      mPc = pcNew;
   endtask

   // Drive inputs at a falling edge, advance the model, then check at the next falling edge.
   task automatic applyStimulus(input logic pw, input logic iw, input logic fl,
                                input logic bh, input logic [31:0] bt,
                                input logic jh, input logic [31:0] jt, input logic irqIn,
                                input string tag);
      PC_Wen = pw; IF_Wen = iw; IF_Flush = fl;
      branch_hazard = bh; branch_target = bt;
      jump_hazard = jh; jump_target = jt; irq = irqIn;
      modelStep();
      @(negedge clk);
      checkAll(tag);
   endtask

   task automatic idle(input string tag);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, tag);
   endtask

   task automatic branchTo(input logic [31:0] t, input string tag);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, t, 1'b0, 32'd0, 1'b0, tag);
   endtask

   initial begin
      reset = 1'b1;
      PC_Wen = 1'b1; IF_Wen = 1'b1; IF_Flush = 1'b0;
      branch_hazard = 1'b0; branch_target = 32'd0;
      jump_hazard = 1'b0; jump_target = 32'd0; irq = 1'b0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkAll("reset");
      reset = 1'b0;

      // Sequential fetch from the reset vector.
      idle("seq0");
      checkOutput("seq0.instrAt8000_0000", IF_ID_Instruction, 32'h0000_7FFF);
      idle("seq1");
      idle("seq2");
      checkOutput("seq2.pc", PC, 32'h8000_000C);

      // Load-use stall for three cycles at 0x40.
      branchTo(32'h0000_0040, "brTo40");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, "stall");
         checkOutput("stall.pcHeld", PC, 32'h0000_0040);
      end
      idle("resume");
      checkOutput("resume.pc", PC, 32'h0000_0044);

      // Jump with flush, then the same jump stalled for one cycle.
      branchTo(32'h0000_0020, "brTo20");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0100, 1'b0, "jump");
      checkOutput("jump.pc", PC, 32'h0000_0100);
      checkOutput("jump.valid", {31'd0, IF_ID_valid}, 32'd0);
      branchTo(32'h0000_0020, "brTo20b");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0100, 1'b0, "jumpStalled");
      checkOutput("jumpStalled.pc", PC, 32'h0000_0020);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0100, 1'b0, "jumpLate");
      checkOutput("jumpLate.pc", PC, 32'h0000_0100);

      // Branch overrides a simultaneous stall.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'd0, 1'b0, "brStall");
      checkOutput("brStall.pc", PC, 32'h0000_0200);
      checkOutput("brStall.instr", IF_ID_Instruction, NOP_INSTR);

      // Interrupt taken from user space.
      branchTo(32'h0000_0080, "brTo80");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, "irqPulse");
      idle("irqTake");
      checkOutput("irqTake.pc", PC, IRQ_VECTOR);
      checkOutput("irqTake.flag", {31'd0, IF_ID_irq}, 32'd1);
      checkOutput("irqTake.pcp4", IF_ID_PC_plus4, 32'h0000_0088);

      // Interrupt held off in supervisor space and during a branch.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, "svIrq");
      idle("svWait0");
      idle("svWait1");
      checkOutput("svWait.noIrq", {31'd0, IF_ID_irq}, 32'd0);
      branchTo(32'h0000_0300, "brTo300");
      idle("svTake");
      checkOutput("svTake.pc", PC, IRQ_VECTOR);
      checkOutput("svTake.pcp4", IF_ID_PC_plus4, 32'h0000_0304);

      // Pending interrupt yields to a jump, then enters.
      branchTo(32'h0000_0010, "brTo10");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, "jiPulse");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0400, 1'b0, "jiJump");
      checkOutput("jiJump.pc", PC, 32'h0000_0400);
      idle("jiTake");
      checkOutput("jiTake.pc", PC, IRQ_VECTOR);
      checkOutput("jiTake.pcp4", IF_ID_PC_plus4, 32'h0000_0404);

      // Reset asserted between edges clears state without waiting for the clock.
      branchTo(32'h0000_0500, "brTo500");
      idle("preReset");
      #2 reset = 1'b1;
      modelReset();
      #1 checkAll("asyncReset");
      @(negedge clk);
      reset = 1'b0;
      idle("postReset");

      // Random traffic; targets mostly land in user space so interrupts get exercised.
      for (int i = 0; i < 400; i++) begin
         logic stall, bh, jh, fl, irqIn;
         logic [31:0] bt, jt;
         stall = ($urandom_range(0, 4) == 0);
         bh    = ($urandom_range(0, 7) == 0);
         jh    = ($urandom_range(0, 7) == 0);
         fl    = jh ? 1'b1 : ($urandom_range(0, 15) == 0);
         irqIn = ($urandom_range(0, 5) == 0);
         bt    = $urandom & 32'h0000_FFFC;
         jt    = $urandom;
         if ($urandom_range(0, 3) != 0) jt = jt & 32'h7FFF_FFFF;
         if ($urandom_range(0, 9) == 0) bt = bt | 32'h8000_0000;
         applyStimulus(!stall, !stall, fl, bh, bt, jh, jt, irqIn, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
